// File: rtl/gates_vector_driver_pkg.sv
// -----------------------------------------------------------------------------
// gates_vector_driver_pkg
// Shared definitions for the gates_vector_driver sweep stage:
//   - FSM state encoding (binary, 2 bits): ST_IDLE=0, ST_DRIVE=1, ST_DONE=2
//   - NUM_VEC : number of input combinations swept (a,b,c -> 8)
//   - CNT_W   : width of the dwell counter
//   - set_bit : helper that returns a vector with one bit replaced
// -----------------------------------------------------------------------------
package gates_vector_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned NUM_VEC  = 8;
  localparam int unsigned CNT_W    = 8;
  localparam logic [2:0]  LAST_VEC = 3'd7;

  // Replace bit 'idx' of 'vec' with 'val', leaving the other bits untouched.
  function automatic logic [7:0] set_bit(input logic [7:0] vec,
                                         input logic [2:0] idx,
                                         input logic       val);
    logic [7:0] tmp;
    tmp      = vec;
    tmp[idx] = val;
    return tmp;
  endfunction

endpackage

// File: rtl/gates_vector_driver_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts the cycles an input vector has been held. The count clears on 'clr',
// advances while 'en' is high and wraps back to 0 on the edge after it reaches
// DWELL-1.
// Ports:
//   clk   in  : rising-edge clock
//   reset in  : asynchronous active-high reset (count -> 0)
//   clr   in  : synchronous clear (wins over en)
//   en    in  : count enable
//   tick  out : high while the count equals DWELL-1
// -----------------------------------------------------------------------------
module dwell_counter
  import gates_vector_driver_pkg::*;
#(
  parameter int unsigned DWELL = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // The counter is only CNT_W bits wide and needs at least two states per
  // vector, so anything outside 2..255 is rejected at elaboration.
  if (DWELL < 2 || DWELL > 255) begin : g_dwell_range_check
    $error("dwell_counter: DWELL must be within 2..255");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-count logic: clear, wrap at DWELL-1, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/gates_vector_driver.sv
// -----------------------------------------------------------------------------
// gates_vector_driver
// Stimulus-and-capture stage for gates_wire. A start request sweeps the eight
// combinations of a/b/c in ascending order, holding each for DWELL cycles, and
// samples the returned d on the last cycle of each hold into 'result'. At the
// end of the sweep 'result' is compared against the EXPECT truth table.
// Ports:
//   clk     in     : rising-edge clock
//   reset   in     : asynchronous active-high reset
//   start   in     : begins a sweep when seen in IDLE or DONE
//   a,b,c   out    : registered stimulus (vec_idx bits 2,1,0 while driving)
//   d       in     : response from gates_wire
//   vec_idx out[3] : index of the vector being driven (holds 7 in DONE)
//   busy    out    : sweep in progress
//   done    out    : sweep finished (level, held until restart/reset)
//   result  out[8] : captured d, bit i for vector i
//   pass    out    : done and result == EXPECT
// -----------------------------------------------------------------------------
module gates_vector_driver
  import gates_vector_driver_pkg::*;
#(
  parameter int unsigned DWELL  = 10,
  parameter logic [7:0]  EXPECT = 8'hEA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       pass
);

  state_e     state_q, state_d;
  logic [2:0] vec_idx_q, vec_idx_d;
  logic [7:0] result_q, result_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       c_q, c_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       cnt_clr;
  logic       cnt_en;
  logic       tick;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tick  (tick)
  );

  // Next-state, vector index and capture logic.
  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    result_d  = result_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          vec_idx_d = 3'd0;
          result_d  = 8'h00;
          cnt_clr   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        // start is deliberately not looked at here: a sweep runs to the end.
        cnt_en = 1'b1;
        if (tick) begin
          result_d = set_bit(result_q, vec_idx_q, d);
          if (vec_idx_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            vec_idx_d = vec_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        vec_idx_d = 3'd0;
        result_d  = 8'h00;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Output values are derived from the next state so the registered outputs
  // line up with the state register (a/b/c change on the same edge as state).
  always_comb begin
    busy_d = (state_d == ST_DRIVE);
    done_d = (state_d == ST_DONE);
    if (busy_d) begin
      a_d = vec_idx_d[2];
      b_d = vec_idx_d[1];
      c_d = vec_idx_d[0];
    end else begin
      a_d = 1'b0;
      b_d = 1'b0;
      c_d = 1'b0;
    end
    pass_d = done_d & (result_d == EXPECT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      vec_idx_q <= 3'd0;
      result_q  <= 8'h00;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      result_q  <= result_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign vec_idx = vec_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_gates_vector_driver.sv
// -----------------------------------------------------------------------------
// tb_gates_vector_driver
// Two instances: u_dut (DWELL=10, EXPECT=EA) with a selectable d model, and
// u_dut2 (DWELL=2, EXPECT=AA) where d follows c (optionally one cycle late, so
// only a capture on the second cycle of each vector yields AA).
// -----------------------------------------------------------------------------
module tb_gates_vector_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       start = 1'b0;
  logic       a, b, c, d;
  logic [2:0] vec_idx;
  logic       busy, done, pass;
  logic [7:0] result;

  logic       start2 = 1'b0;
  logic       a2, b2, c2, d2;
  logic [2:0] vec_idx2;
  logic       busy2, done2, pass2;
  logic [7:0] result2;

  int         mode = 0;
  logic       d2_late = 1'b0;
  logic       c2_dly = 1'b0;
  int         inst_sel = 0;

  int         total = 0;
  int         bad = 0;

  logic [2:0] obs_abc, obs_vec;
  logic       obs_busy, obs_done, obs_pass;
  logic [7:0] obs_res;

  always #5 clk = ~clk;

  gates_vector_driver #(.DWELL(10), .EXPECT(8'hEA)) u_dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c(c), .d(d),
    .vec_idx(vec_idx), .busy(busy), .done(done), .result(result), .pass(pass)
  );

  gates_vector_driver #(.DWELL(2), .EXPECT(8'hAA)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .c(c2), .d(d2),
    .vec_idx(vec_idx2), .busy(busy2), .done(done2), .result(result2), .pass(pass2)
  );

  // Models of the downstream gate network.
  always_comb begin
    case (mode)
      0:       d = (a & b) | c;
      1:       d = a & b & c;
      2:       d = a;
      3:       d = b ^ c;
      default: d = 1'b0;
    endcase
  end

  always @(posedge clk) c2_dly <= c2;
  assign d2 = d2_late ? c2_dly : c2;

  always_comb begin
    if (inst_sel == 0) begin
      obs_abc = {a, b, c}; obs_vec = vec_idx; obs_busy = busy;
      obs_done = done; obs_pass = pass; obs_res = result;
    end else begin
      obs_abc = {a2, b2, c2}; obs_vec = vec_idx2; obs_busy = busy2;
      obs_done = done2; obs_pass = pass2; obs_res = result2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_start(input int inst, input logic v);
    if (inst == 0) start = v; else start2 = v;
  endtask

  // Pulse start for one edge; returns #1 after that edge (T0).
  task automatic pulse_start(input int inst);
    @(negedge clk);
    drive_start(inst, 1'b1);
    @(posedge clk);
    #1;
    drive_start(inst, 1'b0);
  endtask

  // Full sweep with cycle-by-cycle trace check. glitch_k >= 0 re-asserts
  // start for one edge at that cycle offset.
  task automatic run_sweep(input int inst, input int dwell, input logic [7:0] exp_res,
                           input logic exp_pass, input int glitch_k);
    logic [2:0] idx;
    inst_sel = inst;
    pulse_start(inst);
    chk("restart_clear", {obs_done, obs_pass, obs_res}, 32'h0);
    for (int k = 0; k < 8 * dwell; k++) begin
      idx = 3'(k / dwell);
      chk("trace", {obs_abc, obs_vec, obs_busy, obs_done},
          {idx, idx, 1'b1, 1'b0});
      if (k == glitch_k) drive_start(inst, 1'b1);
      @(posedge clk);
      #1;
      drive_start(inst, 1'b0);
    end
    chk("end_state", {obs_abc, obs_vec, obs_busy, obs_done}, {3'd0, 3'd7, 1'b0, 1'b1});
    chk("result", obs_res, exp_res);
    chk("pass", obs_pass, exp_pass);
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", {obs_done, obs_pass, obs_res, obs_busy}, {1'b1, exp_pass, exp_res, 1'b0});
  endtask

  typedef struct {
    int         mode;
    logic [7:0] exp_res;
    logic       exp_pass;
    int         glitch_k;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{0, 8'hEA, 1'b1, -1};
    tbl[1] = '{1, 8'h80, 1'b0, -1};
    tbl[2] = '{2, 8'hF0, 1'b0, -1};
    tbl[3] = '{3, 8'h66, 1'b0, -1};
    tbl[4] = '{0, 8'hEA, 1'b1, 25};

    // Reset state.
    #12;
    chk("reset_outputs", {a, b, c, vec_idx, busy, done, pass, result}, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {a, b, c, vec_idx, busy, done, pass, result}, 32'h0);

    // Table-driven sweeps on the DWELL=10 instance; each after the first
    // restarts from DONE.
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_sweep(0, 10, tbl[i].exp_res, tbl[i].exp_pass, tbl[i].glitch_k);
    end

    // Minimum dwell: combinational d, then d one cycle late.
    d2_late = 1'b0;
    run_sweep(1, 2, 8'hAA, 1'b1, -1);
    d2_late = 1'b1;
    run_sweep(1, 2, 8'hAA, 1'b1, -1);

    // Reset mid-sweep while vector 4 is driven.
    mode = 0;
    inst_sel = 0;
    pulse_start(0);
    repeat (43) @(posedge clk);
    #1;
    chk("pre_reset_idx", {a, b, c, vec_idx, busy}, {3'd4, 3'd4, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {a, b, c, vec_idx, busy, done, pass, result}, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_start", {a, b, c, vec_idx, busy, done, pass, result}, 32'h0);
    run_sweep(0, 10, 8'hEA, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
